dodge_engine: RTL and testbench
===============================

DODGE_ENGINE -- requirements
Module: dodge_engine

Interface
REQ-001 Parameter COLS, default 8: matrix width in columns (>=2).
REQ-002 Parameter ROWS, default 8: obstacle field depth in rows (>=2).
REQ-003 Parameter LIVES, default 3: lives granted at game start (1..15).
REQ-004 Parameter WRAP, default 1: 1 = player rotates at edges, 0 = player saturates at edges.
REQ-005 Parameter HIT_TICKS, default 4: invulnerability length in ticks (>=1).
REQ-006 Parameter SCORE_W, default 8: score width.
REQ-007 clk  in  1  system clock; all state updates on rising edge.
REQ-008 reset  in  1  asynchronous, active-high.
REQ-009 tick  in  1  one-cycle game-step strobe.
REQ-010 left, right  in  1 each  one-cycle move pulses, already debounced.
REQ-011 start  in  1  one-cycle start/restart pulse.
REQ-012 obstacle_in  in  COLS  pattern injected into row 0 on each shift.
REQ-013 player  out  COLS  one-hot player column; all-zero in OVER.
REQ-014 field  out  ROWS*COLS  obstacle rows; row r occupies bits [r*COLS +: COLS]; row ROWS-1 is the player row.
REQ-015 coll  out  1  one-cycle pulse per counted collision.
REQ-016 lives  out  4  remaining lives.
REQ-017 score  out  SCORE_W  survived ticks.
REQ-018 state  out  2  IDLE=0, RUN=1, HIT=2, OVER=3.
REQ-019 game_over  out  1  high exactly while state==OVER.

Function
REQ-020 IDLE: field, score, and lives are held; start moves to RUN next cycle; all other inputs are ignored.
REQ-021 RUN/HIT moves: left only -> player shifts one column toward the MSB; right only -> one column toward the LSB; both or neither -> player is held.
REQ-022 At an edge with WRAP=1, player rotates (MSB<->LSB); with WRAP=0, player is held at the edge.
REQ-023 RUN/HIT tick: each row r moves to row r+1, obstacle_in is loaded into row 0, and the old row ROWS-1 is discarded; latency is one clk.
REQ-024 RUN tick without a collision increments score by 1, saturating at all-ones.
REQ-025 Collision condition: (player & field row ROWS-1) != 0, evaluated on registered values every cycle in RUN.
REQ-026 RUN collision: coll pulses for one cycle, lives decrements by 1, and the move and tick of that same cycle are ignored.
REQ-027 After a RUN collision, state goes to OVER if the decremented lives value is 0, otherwise to HIT.
REQ-028 HIT: collisions are ignored and coll stays 0; moves and ticks behave as in RUN, but score does not increment.
REQ-029 HIT: an internal counter counts HIT_TICKS ticks, then state returns to RUN on the cycle after the last counted tick.
REQ-030 OVER: field, score, and lives are frozen, and player is forced to 0.
REQ-031 OVER: start reinitialises player, field, score, and lives (same values as reset) and enters RUN.
REQ-032 RUN/HIT: start is ignored.
REQ-033 The collision state transition and the coll pulse occur on the clk edge after the collision condition becomes true; coll never asserts in IDLE, HIT, or OVER.
REQ-034 Simultaneous tick and move in a non-collision cycle: both apply, and the collision check for the next cycle uses the new values.

Reset
REQ-035 While reset is high, outputs take these values asynchronously: state=IDLE, player=1 (column 0), field=0, coll=0, lives=LIVES, score=0, game_over=0, internal HIT counter=0.
REQ-036 Reset asserted mid-operation in any state, including HIT or OVER, overrides everything within the same cycle; after release the block waits in IDLE for start.

Verification
REQ-037 Move and wrap (COLS=8, WRAP=1): start, then one right pulse -> player=8'h80; then one left pulse -> player=8'h01.
REQ-038 Saturate and simultaneous (WRAP=0): start, then one right pulse -> player stays 8'h01; left and right pulsed in the same cycle -> player unchanged.
REQ-039 Shift latency (ROWS=8): start; obstacle_in=8'h10 for one tick, then 0 -> the pattern appears in row k after k+1 ticks and reaches row 7 after the 8th tick; score=8 if no collision occurs.
REQ-040 Collision and invulnerability: player=8'h10 while 8'h10 reaches row 7 -> coll is one cycle high, lives 3->2, state=HIT; further overlap during the HIT_TICKS=4 ticks gives no coll; after the 4th tick, state=RUN.
REQ-041 Game over and restart: LIVES=1, force one collision -> state=OVER, game_over=1, player=0, and ticks change nothing; a start pulse -> state=RUN, lives=1, score=0, field=0, player=8'h01.
REQ-042 Reset mid-HIT: reset asserted in HIT -> all outputs take their reset values immediately; after release, state=IDLE.

Source files
------------

// File: rtl/dodge_engine.sv
// Falling-obstacle dodge game core: player row at the bottom of a shifting obstacle field,
// with lives, score and a timed invulnerability window after each collision.
//
// state | meaning
// IDLE  | waiting for start after reset; all game state held
// RUN   | normal play; collisions counted, score counts ticks
// HIT   | invulnerable for HIT_TICKS ticks; no score, no collisions
// OVER  | lives exhausted; field/score/lives frozen, player hidden
module dodge_engine #(
  parameter int COLS      = 8,
  parameter int ROWS      = 8,
  parameter int LIVES     = 3,
  parameter int WRAP      = 1,
  parameter int HIT_TICKS = 4,
  parameter int SCORE_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 left,
  input  logic                 right,
  input  logic                 start,
  input  logic [COLS-1:0]      obstacle_in,
  output logic [COLS-1:0]      player,
  output logic [ROWS*COLS-1:0] field,
  output logic                 coll,
  output logic [3:0]           lives,
  output logic [SCORE_W-1:0]   score,
  output logic [1:0]           state,
  output logic                 game_over
);

  localparam int CNT_W = $clog2(HIT_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HIT  = 2'd2,
    S_OVER = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [COLS-1:0]     pos_q, pos_d;
  logic [ROWS*COLS-1:0] field_q, field_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [3:0]          lives_q, lives_d;
  logic                coll_q, coll_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [COLS-1:0]      pos_left, pos_right, pos_moved;
  logic [ROWS*COLS-1:0] field_shift;
  logic                 overlap;

  // Edge behaviour: rotate when WRAP is set, otherwise hold at the edge.
  always_comb begin
    if (WRAP != 0) begin
      pos_left  = {pos_q[COLS-2:0], pos_q[COLS-1]};
      pos_right = {pos_q[0], pos_q[COLS-1:1]};
    end else begin
      pos_left  = pos_q[COLS-1] ? pos_q : {pos_q[COLS-2:0], 1'b0};
      pos_right = pos_q[0]      ? pos_q : {1'b0, pos_q[COLS-1:1]};
    end
  end

  assign pos_moved   = (left && !right) ? pos_left :
                       (right && !left) ? pos_right : pos_q;
  assign field_shift = {field_q[(ROWS-1)*COLS-1:0], obstacle_in};
  assign overlap     = |(pos_q & field_q[(ROWS-1)*COLS +: COLS]);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    field_d = field_q;
    score_d = score_q;
    lives_d = lives_q;
    coll_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        // A collision swallows the move and tick of the same cycle.
        if (overlap) begin
          coll_d  = 1'b1;
          lives_d = lives_q - 4'd1;
          cnt_d   = CNT_W'(HIT_TICKS);
          state_d = (lives_q == 4'd1) ? S_OVER : S_HIT;
        end else begin
          pos_d = pos_moved;
          if (tick) begin
            field_d = field_shift;
            if (score_q != {SCORE_W{1'b1}}) score_d = score_q + SCORE_W'(1);
          end
        end
      end
      S_HIT: begin
        pos_d = pos_moved;
        if (tick) begin
          field_d = field_shift;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_RUN;
        end
      end
      S_OVER: begin
        if (start) begin
          pos_d   = COLS'(1);
          field_d = '0;
          score_d = '0;
          lives_d = 4'(LIVES);
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pos_q   <= COLS'(1);
      field_q <= '0;
      score_q <= '0;
      lives_q <= 4'(LIVES);
      coll_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      field_q <= field_d;
      score_q <= score_d;
      lives_q <= lives_d;
      coll_q  <= coll_d;
      cnt_q   <= cnt_d;
    end
  end

  assign player    = (state_q == S_OVER) ? '0 : pos_q;
  assign field     = field_q;
  assign coll      = coll_q;
  assign lives     = lives_q;
  assign score     = score_q;
  assign state     = state_q;
  assign game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_dodge_engine.sv
// Bench for dodge_engine: two instances (wrapping, 3 lives / saturating, 1 life, 4-bit score)
// share stimulus and are compared each cycle against a column-index/row-array game model.
module tb_dodge_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0, left = 1'b0, right = 1'b0, start = 1'b0;
  logic [7:0] obs = 8'h00;

  logic [7:0]  p0, p1;
  logic [63:0] f0, f1;
  logic        c0, c1, g0, g1;
  logic [3:0]  l0, l1;
  logic [7:0]  s0;
  logic [3:0]  s1;
  logic [1:0]  st0, st1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dodge_engine #(.COLS(8), .ROWS(8), .LIVES(3), .WRAP(1), .HIT_TICKS(4), .SCORE_W(8)) dut0 (
    .clk(clk), .reset(reset), .tick(tick), .left(left), .right(right), .start(start),
    .obstacle_in(obs), .player(p0), .field(f0), .coll(c0), .lives(l0), .score(s0),
    .state(st0), .game_over(g0));

  dodge_engine #(.COLS(8), .ROWS(8), .LIVES(1), .WRAP(0), .HIT_TICKS(4), .SCORE_W(4)) dut1 (
    .clk(clk), .reset(reset), .tick(tick), .left(left), .right(right), .start(start),
    .obstacle_in(obs), .player(p1), .field(f1), .coll(c1), .lives(l1), .score(s1),
    .state(st1), .game_over(g1));

  // Game model: state 0..3 as named in the interface, player as a column index.
  int         mst[2], pcol[2], mscore[2], mlives[2], mcnt[2];
  bit         mcoll[2];
  logic [7:0] rows[2][8];
  int         lives0[2] = '{3, 1};
  bit         wrap[2]   = '{1'b1, 1'b0};
  int         smax[2]   = '{255, 15};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_init(input int k);
    pcol[k] = 0; mscore[k] = 0; mlives[k] = lives0[k]; mcnt[k] = 0; mcoll[k] = 1'b0;
    for (int r = 0; r < 8; r++) rows[k][r] = 8'h00;
  endtask

  task automatic model_move(input int k, input bit l, input bit r);
    if (l && !r) pcol[k] = (pcol[k] == 7) ? (wrap[k] ? 0 : 7) : pcol[k] + 1;
    else if (r && !l) pcol[k] = (pcol[k] == 0) ? (wrap[k] ? 7 : 0) : pcol[k] - 1;
  endtask

  task automatic model_shift(input int k, input logic [7:0] o);
    for (int r = 7; r > 0; r--) rows[k][r] = rows[k][r-1];
    rows[k][0] = o;
  endtask

  task automatic model_step(input bit t, input bit l, input bit r, input bit s, input logic [7:0] o);
    bit hit;
    for (int k = 0; k < 2; k++) begin
      hit = (mst[k] == 1) && rows[k][7][pcol[k]];
      mcoll[k] = 1'b0;
      case (mst[k])
        0: if (s) mst[k] = 1;
        1: begin
          if (hit) begin
            mcoll[k] = 1'b1;
            mlives[k]--;
            if (mlives[k] == 0) mst[k] = 3;
            else begin mst[k] = 2; mcnt[k] = 4; end
          end else begin
            model_move(k, l, r);
            if (t) begin
              model_shift(k, o);
              if (mscore[k] < smax[k]) mscore[k]++;
            end
          end
        end
        2: begin
          model_move(k, l, r);
          if (t) begin
            model_shift(k, o);
            mcnt[k]--;
            if (mcnt[k] == 0) mst[k] = 1;
          end
        end
        default: if (s) begin model_init(k); mst[k] = 1; end
      endcase
    end
  endtask

  task automatic compare_all();
    logic [63:0] ef;
    logic [7:0]  ep;
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 8; r++) ef[r*8 +: 8] = rows[k][r];
      ep = (mst[k] == 3) ? 8'h00 : 8'(1 << pcol[k]);
      chk($sformatf("player%0d", k), k == 0 ? 64'(p0) : 64'(p1), 64'(ep));
      chk($sformatf("field%0d", k), k == 0 ? f0 : f1, ef);
      chk($sformatf("coll%0d", k), k == 0 ? 64'(c0) : 64'(c1), 64'(mcoll[k]));
      chk($sformatf("lives%0d", k), k == 0 ? 64'(l0) : 64'(l1), 64'(mlives[k]));
      chk($sformatf("score%0d", k), k == 0 ? 64'(s0) : 64'(s1), 64'(mscore[k]));
      chk($sformatf("state%0d", k), k == 0 ? 64'(st0) : 64'(st1), 64'(mst[k]));
      chk($sformatf("game_over%0d", k), k == 0 ? 64'(g0) : 64'(g1), 64'(mst[k] == 3));
    end
  endtask

  // Called at a falling edge: drive inputs for the next rising edge, then compare after it.
  task automatic cycle(input bit t, input bit l, input bit r, input bit s, input logic [7:0] o);
    tick = t; left = l; right = r; start = s; obs = o;
    model_step(t, l, r, s, o);
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset asserted between edges; outputs must change before any clock edge.
  task automatic do_reset();
    tick = 0; left = 0; right = 0; start = 0; obs = 8'h00;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin model_init(k); mst[k] = 0; end
    compare_all();
    chk("rst_state", 64'(st0), 64'd0);
    chk("rst_player", 64'(p0), 64'h01);
    chk("rst_field", f0, 64'd0);
    chk("rst_lives", 64'(l0), 64'd3);
    chk("rst_score", 64'(s0), 64'd0);
    chk("rst_coll", 64'(c0), 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin model_init(k); mst[k] = 0; end
    repeat (2) @(negedge clk);
    compare_all();
    chk("init_lives1", 64'(l1), 64'd1);
    chk("init_go0", 64'(g0), 64'd0);
    reset = 1'b0;

    // Moves, wrap vs saturate, simultaneous pulses.
    cycle(0, 0, 0, 1, 8'h00);
    chk("run_state", 64'(st0), 64'd1);
    cycle(0, 0, 1, 0, 8'h00);
    chk("wrap_right", 64'(p0), 64'h80);
    chk("sat_right", 64'(p1), 64'h01);
    cycle(0, 1, 0, 0, 8'h00);
    chk("wrap_left", 64'(p0), 64'h01);
    chk("sat_left", 64'(p1), 64'h02);
    cycle(0, 1, 1, 0, 8'h00);
    chk("both_hold0", 64'(p0), 64'h01);
    chk("both_hold1", 64'(p1), 64'h02);

    // Shift latency: pattern in row k after k+1 ticks.
    do_reset();
    cycle(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, 0, 0, i == 0 ? 8'h10 : 8'h00);
      chk($sformatf("row%0d", i), 64'(f0[i*8 +: 8]), 64'h10);
    end
    chk("score8", 64'(s0), 64'd8);

    // Collision, invulnerability, game over and restart.
    do_reset();
    cycle(0, 0, 0, 1, 8'h00);
    repeat (4) cycle(0, 1, 0, 0, 8'h00);
    chk("pos4_0", 64'(p0), 64'h10);
    chk("pos4_1", 64'(p1), 64'h10);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, i == 0 ? 8'h10 : 8'h00);
    chk("pre_coll", 64'(c0), 64'd0);
    cycle(0, 0, 0, 0, 8'h00);
    chk("coll0", 64'(c0), 64'd1);
    chk("lives_2", 64'(l0), 64'd2);
    chk("state_hit", 64'(st0), 64'd2);
    chk("over_state", 64'(st1), 64'd3);
    chk("over_go", 64'(g1), 64'd1);
    chk("over_player", 64'(p1), 64'h00);
    repeat (3) begin
      cycle(0, 0, 0, 0, 8'h00);
      chk("hit_nocoll", 64'(c0), 64'd0);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 0, 8'h00);
      chk("hit_len", 64'(st0), i < 3 ? 64'd2 : 64'd1);
    end
    chk("over_frozen", 64'(s1), 64'd8);
    cycle(0, 0, 0, 1, 8'h00);
    chk("restart_state", 64'(st1), 64'd1);
    chk("restart_lives", 64'(l1), 64'd1);
    chk("restart_score", 64'(s1), 64'd0);
    chk("restart_field", f1, 64'd0);
    chk("restart_player", 64'(p1), 64'h01);
    chk("run_ign_start", 64'(l0), 64'd2);

    // Reset in the middle of HIT.
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, i == 0 ? 8'h10 : 8'h00);
    cycle(0, 0, 0, 0, 8'h00);
    chk("hit_again", 64'(st0), 64'd2);
    cycle(1, 0, 0, 0, 8'h00);
    do_reset();
    cycle(1, 1, 0, 0, 8'hff);
    chk("idle_wait", 64'(st0), 64'd0);

    // Score saturation on the 4-bit instance.
    cycle(0, 0, 0, 1, 8'h00);
    repeat (20) cycle(1, 0, 0, 0, 8'h00);
    chk("sat_score1", 64'(s1), 64'd15);
    chk("score20", 64'(s0), 64'd20);

    // Random play.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                 8'($urandom & $urandom & $urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
